// File: rtl/rombox_latch_sync.sv
// RomBox bank ($BFFF) and switch-override ($BFFE) registers, over-sampling the 6502 bus on Clk.
// Optional $BFFE unlock sequence (5, A, then value) is enabled by defining SWLOCK_EN.
module rombox_latch_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int MIN_HIGH      = 2,
   parameter int UNLOCK_WINDOW = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PHI2,
   input  logic [15:0] Addr,
   input  logic        RW,
   input  logic [3:0]  DataIn,
   input  logic        DskRAMSW,
   input  logic        DskROMSW,
   output logic [3:0]  RomLatch,
   output logic [3:0]  SwitchLatch,
   output logic [3:0]  DataOut,
   output logic        DataOE,
   output logic        WrStrobe,
   output logic        Locked
);

   localparam int HCNT_W = (MIN_HIGH < 1) ? 1 : $clog2(MIN_HIGH + 1);

   typedef struct packed {
      logic [15:0] addr;
      logic        rw;
      logic [3:0]  data;
   } bus_t;

   typedef enum logic [1:0] {
      BUS_IDLE = 2'd0,
      BUS_HIGH = 2'd1,
      BUS_FALL = 2'd2
   } bus_state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   phi2_s;
   bus_t [SYNC_STAGES:0]   dly_q, dly_d;
   bus_t                   cmd_q, cmd_d;
   bus_state_t             bus_q, bus_d;
   logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
   logic                   arm_q, arm_d;
   logic [3:0]             rom_q, rom_d;
   logic [3:0]             sw_q, sw_d;

   logic fall;
   logic rom_hit;
   logic sw_hit;
   logic sw_commit;

   // PHI2 synchroniser and bus delay line
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], PHI2};
      dly_d  = {dly_q[SYNC_STAGES-1:0], bus_t'({Addr, RW, DataIn})};
   end

   assign phi2_s = sync_q[SYNC_STAGES-1];

   // Bus cycle tracker. The FALL decision is made SYNC_STAGES+1 Clk after the
   // raw fall, so tap SYNC_STAGES holds the bus as it was one Clk before it.
   always_comb begin
      bus_d  = bus_q;
      hcnt_d = hcnt_q;
      cmd_d  = cmd_q;
      arm_d  = arm_q | ~phi2_s;
      case (bus_q)
         BUS_IDLE: begin
            if (arm_q && phi2_s) begin
               bus_d  = BUS_HIGH;
               hcnt_d = '0;
            end
         end
         BUS_HIGH: begin
            if (phi2_s) begin
               if (hcnt_q < HCNT_W'(MIN_HIGH)) hcnt_d = hcnt_q + HCNT_W'(1);
            end else if (hcnt_q >= HCNT_W'(MIN_HIGH)) begin
               bus_d = BUS_FALL;
               cmd_d = dly_q[SYNC_STAGES];
            end else begin
               bus_d = BUS_IDLE;
            end
         end
         BUS_FALL: bus_d = BUS_IDLE;
         default:  bus_d = BUS_IDLE;
      endcase
   end

   assign fall    = (bus_q == BUS_FALL);
   assign rom_hit = fall && !cmd_q.rw && (cmd_q.addr == 16'hBFFF);
   assign sw_hit  = fall && !cmd_q.rw && (cmd_q.addr == 16'hBFFE);

`ifdef SWLOCK_EN
   localparam int WIN_W = $clog2(UNLOCK_WINDOW + 1);

   typedef enum logic [1:0] {
      LK_LOCKED = 2'd0,
      LK_KEY1   = 2'd1,
      LK_OPEN   = 2'd2
   } lock_state_t;

   lock_state_t      lock_q, lock_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic             expired;

   assign expired = (lock_q != LK_LOCKED) && (win_q == WIN_W'(UNLOCK_WINDOW));

   // Unlock sequencer; an expired window wins over whatever the cycle carried
   always_comb begin
      lock_d    = lock_q;
      win_d     = win_q;
      sw_commit = 1'b0;
      if (fall) begin
         if (expired) begin
            lock_d = LK_LOCKED;
         end else if (sw_hit) begin
            case (lock_q)
               LK_LOCKED: begin
                  if (cmd_q.data == 4'h5) begin
                     lock_d = LK_KEY1;
                     win_d  = '0;
                  end
               end
               LK_KEY1: begin
                  if (cmd_q.data == 4'hA) begin
                     lock_d = LK_OPEN;
                     win_d  = '0;
                  end else begin
                     lock_d = LK_LOCKED;
                  end
               end
               LK_OPEN: begin
                  sw_commit = 1'b1;
                  lock_d    = LK_LOCKED;
               end
               default: lock_d = LK_LOCKED;
            endcase
         end else if (win_q != WIN_W'(UNLOCK_WINDOW)) begin
            win_d = win_q + WIN_W'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lock_q <= LK_LOCKED;
         win_q  <= '0;
      end else begin
         lock_q <= lock_d;
         win_q  <= win_d;
      end
   end

   assign Locked = (lock_q != LK_OPEN);
`else
   assign sw_commit = sw_hit;
   assign Locked    = 1'b0;
`endif

   always_comb begin
      rom_d = rom_q;
      sw_d  = sw_q;
      if (rom_hit)   rom_d = cmd_q.data;
      if (sw_commit) sw_d  = cmd_q.data;
   end

   always_ff @(posedge Clk) begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      cmd_q  <= cmd_d;
      if (Reset) begin
         bus_q  <= BUS_IDLE;
         hcnt_q <= '0;
         arm_q  <= 1'b0;
         rom_q  <= 4'h0;
         sw_q   <= 4'h0;
      end else begin
         bus_q  <= bus_d;
         hcnt_q <= hcnt_d;
         arm_q  <= arm_d;
         rom_q  <= rom_d;
         sw_q   <= sw_d;
      end
   end

   assign RomLatch    = rom_q;
   assign SwitchLatch = sw_q;
   assign WrStrobe    = ~Reset & (rom_hit | sw_commit);

   // Readback follows the live bus so data is driven for the whole PHI2-high phase
   always_comb begin
      DataOE  = PHI2 & RW &
                ((Addr == 16'hBFFF) | (Addr == 16'hBFFE) | (Addr == 16'hBFFD));
      DataOut = 4'h0;
      if (DataOE) begin
         case (Addr)
            16'hBFFF: DataOut = rom_q;
            16'hBFFE: DataOut = sw_q;
            default:  DataOut = {1'b0, ~DskROMSW, ~DskRAMSW, 1'b0};
         endcase
      end
   end

endmodule
